ram_access_ctrl: RTL and testbench
==================================

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameters SHALL be: DW, default 32, data width (multiple of 8); AW, default 32, address width.
REQ-002 Ports SHALL be: clk  input  1  clock, rising-edge active.
REQ-003 rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 req_valid  input  1  request present; req_ready  output  1  request accepted when both high at clk edge.
REQ-005 req_we  input  1  1=write, 0=read; req_addr  input  AW  word address; req_wdata  input  DW  write data; req_wstrb  input  DW/8  byte enables.
REQ-006 rsp_valid  output  1  response present; rsp_ready  input  1  response consumed when both high at clk edge; rsp_rdata  output  DW  read data.
REQ-007 ram_wen  output  1;  ram_ren  output  1;  ram_addr  output  AW;  ram_wdata  output  DW: drive a single-port synchronous RAM.
REQ-008 ram_rdata  input  DW  RAM read data, valid the cycle after ram_ren=1.

Function
REQ-009 The FSM SHALL have states IDLE, RD_DATA, RMW_WR and RSP.
REQ-010 req_ready SHALL be 1 only in IDLE; every accepted request SHALL produce exactly one response.
REQ-011 In IDLE with req_valid=1, RAM controls SHALL be driven combinationally from the request in the same cycle as acceptance (cycle T).
REQ-012 Read: ram_ren=1 and ram_addr=req_addr in T; T+1 state RD_DATA, ram_rdata registered into rsp_rdata; T+2 state RSP, rsp_valid=1.
REQ-013 Full write (wstrb all ones): ram_wen=1, ram_addr=req_addr, ram_wdata=req_wdata in T; T+1 state RSP, rsp_valid=1, rsp_rdata=0.
REQ-014 Partial write (wstrb neither all ones nor zero): ram_ren=1 in T, with addr, wdata and wstrb latched; T+1 state RMW_WR, ram_wen=1, ram_addr=latched addr.
REQ-015 In RMW_WR, ram_wdata byte i SHALL be the latched wdata byte i when strobe bit i=1, else ram_rdata byte i; T+2 state RSP, rsp_rdata=0.
REQ-016 Write with wstrb=0 SHALL issue no RAM access; T+1 state RSP, rsp_rdata=0.
REQ-017 ram_wen and ram_ren SHALL never be 1 in the same cycle.
REQ-018 ram_ren SHALL be 1 only in IDLE; ram_wen SHALL be 1 only in IDLE (full write) or RMW_WR.
REQ-019 When both enables are 0, ram_addr and ram_wdata SHALL be 0.
REQ-020 In RSP, rsp_valid and rsp_rdata SHALL hold stable until rsp_ready=1; on handshake the state SHALL go to IDLE, with rsp_valid=0 the next cycle.
REQ-021 Request inputs SHALL be ignored outside IDLE; a request held valid during RSP SHALL be accepted in the first IDLE cycle after.
REQ-022 Addresses SHALL pass unchecked; ram_addr equals req_addr (or latched addr) bit-for-bit.

Reset
REQ-023 While rstn=0, state SHALL be IDLE and rsp_valid=0, rsp_rdata=0, latched addr/wdata/wstrb=0, req_ready=1 (combinational).
REQ-024 rstn falling mid-RD_DATA or mid-RMW_WR SHALL drop ram_wen/ram_ren to 0 asynchronously; an aborted RMW write SHALL not occur, and no response is produced.
REQ-025 After rstn rises, the first request SHALL be accepted on the first clk edge with req_valid=1.

Verification
REQ-026 Full write addr 0x10 data 0xDEADBEEF, then read addr 0x10 -> ram_wen one cycle, write rsp at T+1, read rsp_rdata=0xDEADBEEF at T+2.
REQ-027 Mem[0x20]=0x11223344, write wstrb=4'b0101 data 0xAABBCCDD, then read -> RAM gets 0x11BB33DD in RMW_WR; readback 0x11BB33DD; ram_wen & ram_ren never both 1.
REQ-028 Read with rsp_ready=0 for 5 cycles -> rsp_valid=1 and rsp_rdata stable all 5 cycles, req_ready=0; IDLE one cycle after handshake.
REQ-029 Write with wstrb=0 -> no ram_wen/ram_ren pulse, rsp_valid at T+1, rsp_rdata=0, memory unchanged.
REQ-030 Assert rstn=0 during RMW_WR of wstrb=4'b0001 to addr 0x30 -> ram_wen falls immediately; Mem[0x30] unchanged; rsp_valid=0; post-reset read returns old value.
REQ-031 Back-to-back 100 random read/write/strobe requests with random rsp_ready -> responses in order, one per request, read data matching a byte-wise reference model.

Source files
------------

// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl
//
// Sits between a simple valid/ready request/response channel and a
// single-port synchronous RAM. Each request produces exactly one response.
// Four kinds of request are handled:
//   - read:           RAM read in the accept cycle. Data is captured one cycle
//                     later and returned in RSP.
//   - full write:     all strobes set. RAM write in the accept cycle, then RSP.
//   - partial write:  read-modify-write. The RAM is read in the accept cycle.
//                     The merged word is written in RMW_WR, then RSP.
//   - empty write:    no strobes set. No RAM access; go straight to RSP.
// Only one request is outstanding at a time. req_ready is high only in IDLE.
//
// Parameters
//   DW  data width in bits (multiple of 8)
//   AW  word-address width in bits
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   req_valid  request present
//   req_ready  request accepted when req_valid && req_ready at a clk edge
//   req_we     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_wstrb  byte enables, one per data byte
//   rsp_valid  response present, held until rsp_ready
//   rsp_ready  response consumed when rsp_valid && rsp_ready at a clk edge
//   rsp_rdata  read data (zero for writes)
//   ram_wen    RAM write enable
//   ram_ren    RAM read enable
//   ram_addr   RAM address (zero when idle)
//   ram_wdata  RAM write data (zero when idle)
//   ram_rdata  RAM read data, valid the cycle after ram_ren

module ram_access_ctrl #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    input  logic [DW/8-1:0] req_wstrb,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_wen,
    output logic          ram_ren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RMW_WR  = 2'd2,
        RSP     = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // Request fields kept for the write half of a read-modify-write
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic [SW-1:0] lat_wstrb;

    logic          full_strb;
    logic          zero_strb;

    // Raw FSM outputs, gated by rstn below
    logic          ready_raw;
    logic          valid_raw;
    logic          wen_raw;
    logic          ren_raw;
    logic [AW-1:0] addr_raw;
    logic [DW-1:0] wdata_raw;

    logic          load_latch;
    logic          load_rdata;
    logic          clear_rdata;

    // Byte-wise merge: strobed bytes come from new_data, the rest from old_data
    function automatic logic [DW-1:0] merge_bytes(
        input logic [DW-1:0] old_data,
        input logic [DW-1:0] new_data,
        input logic [SW-1:0] strb
    );
        logic [DW-1:0] merged;
        merged = old_data;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return merged;
    endfunction

    assign full_strb = &req_wstrb;
    assign zero_strb = ~|req_wstrb;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and RAM/handshake controls
    always_comb begin
        state_next  = state;
        ready_raw   = 1'b0;
        valid_raw   = 1'b0;
        wen_raw     = 1'b0;
        ren_raw     = 1'b0;
        addr_raw    = '0;
        wdata_raw   = '0;
        load_latch  = 1'b0;
        load_rdata  = 1'b0;
        clear_rdata = 1'b0;

        case (state)
            IDLE: begin
                ready_raw = 1'b1;
                if (req_valid) begin
                    // Write responses carry zero data; clearing here covers all write kinds
                    clear_rdata = 1'b1;
                    if (!req_we) begin
                        ren_raw    = 1'b1;
                        addr_raw   = req_addr;
                        state_next = RD_DATA;
                    end else if (full_strb) begin
                        wen_raw    = 1'b1;
                        addr_raw   = req_addr;
                        wdata_raw  = req_wdata;
                        state_next = RSP;
                    end else if (zero_strb) begin
                        state_next = RSP;
                    end else begin
                        // Fetch the old word now; the merge happens in RMW_WR
                        ren_raw    = 1'b1;
                        addr_raw   = req_addr;
                        load_latch = 1'b1;
                        state_next = RMW_WR;
                    end
                end
            end

            RD_DATA: begin
                load_rdata = 1'b1;
                state_next = RSP;
            end

            RMW_WR: begin
                wen_raw    = 1'b1;
                addr_raw   = lat_addr;
                wdata_raw  = merge_bytes(ram_rdata, lat_wdata, lat_wstrb);
                state_next = RSP;
            end

            RSP: begin
                valid_raw = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch and response data register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wstrb <= '0;
            rsp_rdata <= '0;
        end else begin
            if (load_latch) begin
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_wstrb <= req_wstrb;
            end
            if (load_rdata) begin
                rsp_rdata <= ram_rdata;
            end else if (clear_rdata) begin
                rsp_rdata <= '0;
            end
        end
    end

    // Outputs. The rstn gating kills an in-flight RAM access the moment
    // reset falls, without waiting for the asynchronous state change to
    // propagate. It also holds req_ready high throughout reset.
    assign req_ready = ready_raw | ~rstn;
    assign rsp_valid = valid_raw & rstn;
    assign ram_wen   = wen_raw & rstn;
    assign ram_ren   = ren_raw & rstn;
    assign ram_addr  = rstn ? addr_raw  : '0;
    assign ram_wdata = rstn ? wdata_raw : '0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural synchronous RAM.
module tb_ram_access_ctrl;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [3:0]    req_wstrb = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_rdata;
    logic          ram_wen;
    logic          ram_ren;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic mon_en = 1'b0;

    // Behavioural RAM plus a bench-side preload port
    logic [DW-1:0] mem [0:255];
    logic          pre_en = 1'b0;
    logic [7:0]    pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    logic [DW-1:0] ref_mem [0:15];

    ram_access_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        else if (ram_wen) mem[ram_addr[7:0]] <= ram_wdata;
        if (ram_ren) ram_rdata <= mem[ram_addr[7:0]];
    end

    // Continuous protocol checks on every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            n_tests++;
            if (ram_wen && ram_ren) begin
                n_fail++; $display("FAIL mon_excl: wen=%0b ren=%0b both high", ram_wen, ram_ren);
            end
            n_tests++;
            if (!ram_wen && !ram_ren && (ram_addr !== '0 || ram_wdata !== '0)) begin
                n_fail++; $display("FAIL mon_idle_bus: addr=%h wdata=%h want 0", ram_addr, ram_wdata);
            end
        end
    end

    task automatic cycle;
        @(posedge clk); #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [DW-1:0] d);
        pre_addr = a; pre_data = d; pre_en = 1'b1;
        cycle();
        pre_en = 1'b0;
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", req_ready); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", rsp_valid); end
        n_tests++; if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        n_tests++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin n_fail++; $display("FAIL rst_en: ren=%0b wen=%0b want 0", ram_ren, ram_wen); end
        n_tests++; if (ram_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", ram_addr); end
        req_valid = 1'b0;
        rstn = 1'b1;
        mon_en = 1'b1;
        cycle();
    endtask

    task automatic test_full_write_read;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_wstrb = 4'hF;
        @(negedge clk);
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fw_ready: got %0b want 1", req_ready); end
        n_tests++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL fw_en: wen=%0b ren=%0b want 1/0", ram_wen, ram_ren); end
        n_tests++; if (ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL fw_bus: addr=%h data=%h want 10/deadbeef", ram_addr, ram_wdata); end
        cycle();
        req_valid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL fw_rsp: valid=%0b rdata=%h want 1/0", rsp_valid, rsp_rdata); end
        n_tests++; if (ram_wen !== 1'b0) begin n_fail++; $display("FAIL fw_wen_once: got %0b want 0", ram_wen); end
        finish_rsp();
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL fw_idle: valid=%0b ready=%0b want 0/1", rsp_valid, req_ready); end
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
        @(negedge clk);
        n_tests++; if (ram_ren !== 1'b1 || ram_addr !== 32'h10) begin n_fail++; $display("FAIL rd_bus: ren=%0b addr=%h want 1/10", ram_ren, ram_addr); end
        cycle();
        req_valid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rd_t1: valid=%0b ready=%0b want 0/0", rsp_valid, req_ready); end
        cycle();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_t2: valid=%0b rdata=%h want 1/deadbeef", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_partial_write;
        poke(8'h20, 32'h11223344);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hAABBCCDD; req_wstrb = 4'b0101;
        @(negedge clk);
        n_tests++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h20) begin n_fail++; $display("FAIL pw_rd: ren=%0b wen=%0b addr=%h want 1/0/20", ram_ren, ram_wen, ram_addr); end
        cycle();
        req_valid = 1'b0; req_wdata = 32'h0; req_wstrb = 4'h0; req_addr = 32'h0;
        n_tests++; if (ram_wen !== 1'b1 || ram_addr !== 32'h20) begin n_fail++; $display("FAIL pw_wr: wen=%0b addr=%h want 1/20", ram_wen, ram_addr); end
        n_tests++; if (ram_wdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL pw_merge: got %h want 11bb33dd", ram_wdata); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL pw_early: got %0b want 0", rsp_valid); end
        cycle();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL pw_rsp: valid=%0b rdata=%h want 1/0", rsp_valid, rsp_rdata); end
        n_tests++; if (mem[8'h20] !== 32'h11BB33DD) begin n_fail++; $display("FAIL pw_mem: got %h want 11bb33dd", mem[8'h20]); end
        finish_rsp();
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        cycle();
        req_valid = 1'b0;
        cycle();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL pw_readback: valid=%0b rdata=%h want 1/11bb33dd", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_backpressure;
        poke(8'h40, 32'hCAFEF00D);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40;
        cycle();
        // Hold a second read pending; it must wait until IDLE
        req_addr = 32'h10;
        n_tests++; if (ram_ren !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ignore: ren=%0b ready=%0b want 0/0", ram_ren, req_ready); end
        cycle();
        for (int k = 0; k < 5; k++) begin
            n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bp_hold%0d: valid=%0b rdata=%h want 1/cafef00d", k, rsp_valid, rsp_rdata); end
            n_tests++; if (req_ready !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL bp_busy%0d: ready=%0b ren=%0b want 0/0", k, req_ready, ram_ren); end
            cycle();
        end
        finish_rsp();
        n_tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle: valid=%0b ready=%0b want 0/1", rsp_valid, req_ready); end
        n_tests++; if (ram_ren !== 1'b1 || ram_addr !== 32'h10) begin n_fail++; $display("FAIL bp_pending: ren=%0b addr=%h want 1/10", ram_ren, ram_addr); end
        cycle();
        req_valid = 1'b0;
        cycle();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL bp_second: valid=%0b rdata=%h want 1/deadbeef", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_zero_strobe;
        poke(8'h50, 32'h12345678);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'h0;
        @(negedge clk);
        n_tests++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL zs_en: wen=%0b ren=%0b want 0/0", ram_wen, ram_ren); end
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL zs_ready: got %0b want 1", req_ready); end
        cycle();
        req_valid = 1'b0;
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL zs_rsp: valid=%0b rdata=%h want 1/0", rsp_valid, rsp_rdata); end
        n_tests++; if (mem[8'h50] !== 32'h12345678) begin n_fail++; $display("FAIL zs_mem: got %h want 12345678", mem[8'h50]); end
        finish_rsp();
    endtask

    task automatic test_reset_abort;
        poke(8'h30, 32'hA5A5A5A5);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h000000FF; req_wstrb = 4'b0001;
        @(negedge clk);
        n_tests++; if (ram_ren !== 1'b1) begin n_fail++; $display("FAIL ra_rd: got %0b want 1", ram_ren); end
        cycle();
        req_valid = 1'b0;
        n_tests++; if (ram_wen !== 1'b1 || ram_wdata !== 32'hA5A5A5FF) begin n_fail++; $display("FAIL ra_rmw: wen=%0b data=%h want 1/a5a5a5ff", ram_wen, ram_wdata); end
        #2 rstn = 1'b0;
        #1;
        n_tests++; if (ram_wen !== 1'b0 || ram_ren !== 1'b0) begin n_fail++; $display("FAIL ra_drop: wen=%0b ren=%0b want 0/0", ram_wen, ram_ren); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ra_valid: got %0b want 0", rsp_valid); end
        cycle();
        n_tests++; if (mem[8'h30] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ra_mem: got %h want a5a5a5a5", mem[8'h30]); end
        rstn = 1'b1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h30;
        @(negedge clk);
        n_tests++; if (ram_ren !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL ra_first: ren=%0b ready=%0b want 1/1", ram_ren, req_ready); end
        cycle();
        req_valid = 1'b0;
        cycle();
        n_tests++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL ra_read: valid=%0b rdata=%h want 1/a5a5a5a5", rsp_valid, rsp_rdata); end
        finish_rsp();
    endtask

    task automatic test_back_to_back;
        logic [DW-1:0] exp_data;
        logic [DW-1:0] mask;
        logic [3:0]    a;
        logic [3:0]    s;
        int            sel;
        int            n_rsp;
        bit            got;
        n_rsp = 0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (32'h01010101 * i) ^ 32'h5A5A0000;
            poke(8'h80 + 8'(i), ref_mem[i]);
        end
        for (int n = 0; n < 100; n++) begin
            a   = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 3);
            s   = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(1, 14));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 32'h80 + 32'(a);
            req_wdata = $urandom;
            req_wstrb = s;
            if (!req_we) begin
                exp_data = ref_mem[a];
            end else begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                ref_mem[a] = (ref_mem[a] & ~mask) | (req_wdata & mask);
                exp_data = 32'h0;
            end
            req_valid = 1'b1;
            cycle();
            req_valid = 1'b0;
            got = 1'b0;
            for (int c = 0; c < 40 && !got; c++) begin
                rsp_ready = 1'($urandom_range(0, 1));
                if (rsp_valid && rsp_ready) begin
                    n_tests++;
                    if (rsp_rdata !== exp_data) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", n, rsp_rdata, exp_data); end
                    got = 1'b1;
                    n_rsp++;
                end
                cycle();
            end
            rsp_ready = 1'b0;
            if (!got) begin
                n_tests++; n_fail++;
                $display("FAIL b2b_timeout%0d: no response within 40 cycles", n);
            end
        end
        n_tests++; if (n_rsp != 100) begin n_fail++; $display("FAIL b2b_count: got %0d want 100", n_rsp); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (mem[8'h80 + 8'(i)] !== ref_mem[i]) begin n_fail++; $display("FAIL b2b_mem%0d: got %h want %h", i, mem[8'h80 + 8'(i)], ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_backpressure();
        test_zero_strobe();
        test_reset_abort();
        test_back_to_back();
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
